// File: rtl/lc3_controller_if.sv
// Handshake and control bundle between the LC-3 pipeline controller and the datapath/memories.
// The master side is the controller; the slave side is the datapath or testbench driving status.
interface lc3_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;
  logic        enable_fetch;
  logic        enable_updatePC;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;

  modport master (
    input  complete_instr,
    input  complete_data,
    input  IR_Exec,
    input  psr,
    output enable_fetch,
    output enable_updatePC,
    output enable_decode,
    output enable_execute,
    output enable_writeback,
    output br_taken,
    output mem_state
  );

  modport slave (
    output complete_instr,
    output complete_data,
    output IR_Exec,
    output psr,
    input  enable_fetch,
    input  enable_updatePC,
    input  enable_decode,
    input  enable_execute,
    input  enable_writeback,
    input  br_taken,
    input  mem_state
  );
endinterface

// File: rtl/lc3_controller.sv
// LC-3 pipeline controller: sequences fetch/decode/execute/writeback enables, memory
// access states and branch flushes from the instruction held in the execute stage.
module lc3_controller (
  input  logic              clk,
  input  logic              reset,
  lc3_controller_if.master  ctrl
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    MEM_IND = 3'd1,
    MEM_RD  = 3'd2,
    MEM_WR  = 3'd3,
    BR_WAIT = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_IND   = 2'd1;
  localparam logic [1:0] MS_WRITE = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  state_t     r_state;
  logic       r_vDec;
  logic       r_vExe;
  logic       r_vWb;
  logic       r_brTaken;
  logic [1:0] r_memState;
  logic       r_indStore;

  logic [3:0] w_opcode;
  logic       w_isAlu;
  logic       w_isLoad;
  logic       w_isStore;
  logic       w_isInd;
  logic       w_isBranch;
  logic       w_brCond;
  logic       w_go;
  logic       w_exeAct;
  logic       w_hazard;
  logic       w_enFetch;
  logic       w_enUpdatePC;
  logic       w_enDecode;
  logic       w_enExecute;
  logic       w_enWriteback;
  logic       w_unusedIr;

  assign w_opcode   = ctrl.IR_Exec[15:12];
  assign w_unusedIr = ^ctrl.IR_Exec[8:0];

  assign w_isAlu    = (w_opcode == OP_ADD) || (w_opcode == OP_AND) ||
                      (w_opcode == OP_NOT) || (w_opcode == OP_LEA);
  assign w_isLoad   = (w_opcode == OP_LD)  || (w_opcode == OP_LDR);
  assign w_isStore  = (w_opcode == OP_ST)  || (w_opcode == OP_STR);
  assign w_isInd    = (w_opcode == OP_LDI) || (w_opcode == OP_STI);
  assign w_isBranch = (w_opcode == OP_BR)  || (w_opcode == OP_JMP);
  assign w_brCond   = (w_opcode == OP_JMP) || ((ctrl.IR_Exec[11:9] & ctrl.psr) != 3'b000);

  // r_vWb marks a freshly captured, not yet acted-on instruction in IR_Exec.
  assign w_go      = (r_state == RUN) && ctrl.complete_instr;
  assign w_exeAct  = w_go && r_vWb;
  assign w_hazard  = w_exeAct && (w_isLoad || w_isStore || w_isInd || w_isBranch);

  assign w_enFetch     = !reset && w_go && !w_hazard;
  assign w_enUpdatePC  = w_enFetch || (!reset && (r_state == BR_WAIT));
  assign w_enDecode    = w_enFetch && r_vDec;
  assign w_enExecute   = w_enFetch && r_vExe;
  assign w_enWriteback = !reset && ((w_exeAct && w_isAlu) ||
                                    ((r_state == MEM_RD) && ctrl.complete_data));

  assign ctrl.enable_fetch     = w_enFetch;
  assign ctrl.enable_updatePC  = w_enUpdatePC;
  assign ctrl.enable_decode    = w_enDecode;
  assign ctrl.enable_execute   = w_enExecute;
  assign ctrl.enable_writeback = w_enWriteback;
  assign ctrl.br_taken         = r_brTaken;
  assign ctrl.mem_state        = r_memState;

  // A hazard cycle consumes the execute instruction and freezes the front of the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_vDec     <= 1'b0;
      r_vExe     <= 1'b0;
      r_vWb      <= 1'b0;
      r_brTaken  <= 1'b0;
      r_memState <= MS_IDLE;
      r_indStore <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_enFetch) begin
            r_vDec <= 1'b1;
            r_vExe <= r_vDec;
            r_vWb  <= r_vExe;
          end
          if (w_hazard) begin
            r_vWb <= 1'b0;
            if (w_isLoad) begin
              r_state    <= MEM_RD;
              r_memState <= MS_READ;
            end else if (w_isInd) begin
              r_state    <= MEM_IND;
              r_memState <= MS_IND;
              r_indStore <= (w_opcode == OP_STI);
            end else if (w_isStore) begin
              r_state    <= MEM_WR;
              r_memState <= MS_WRITE;
            end else begin
              r_state   <= BR_WAIT;
              r_brTaken <= w_brCond;
            end
          end
        end
        MEM_IND: begin
          if (ctrl.complete_data) begin
            if (r_indStore) begin
              r_state    <= MEM_WR;
              r_memState <= MS_WRITE;
            end else begin
              r_state    <= MEM_RD;
              r_memState <= MS_READ;
            end
          end
        end
        MEM_RD, MEM_WR: begin
          if (ctrl.complete_data) begin
            r_state    <= RUN;
            r_memState <= MS_IDLE;
          end
        end
        BR_WAIT: begin
          r_state   <= RUN;
          r_vDec    <= 1'b0;
          r_vExe    <= 1'b0;
          r_vWb     <= 1'b0;
          r_brTaken <= 1'b0;
        end
        default: begin
          r_state    <= RUN;
          r_memState <= MS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_controller.sv
// Directed bench for lc3_controller: each step drives inputs at the falling edge and
// checks {fetch, updatePC, decode, execute, writeback, br_taken, mem_state[1:0]}.
module tb_lc3_controller;

  localparam logic [15:0] I_ADD  = 16'h1000;
  localparam logic [15:0] I_LDR  = 16'h6000;
  localparam logic [15:0] I_LD   = 16'h2000;
  localparam logic [15:0] I_STI  = 16'hB000;
  localparam logic [15:0] I_NOP  = 16'hD000;
  localparam logic [15:0] I_BRZ  = 16'h0400;

  logic clk;
  logic reset;
  int   nVectors;
  int   nMiscompares;

  lc3_controller_if bif ();

  lc3_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic ci, input logic cd,
                               input logic [15:0] ir, input logic [2:0] p);
    @(negedge clk);
    reset              = rst;
    bif.complete_instr = ci;
    bif.complete_data  = cd;
    bif.IR_Exec        = ir;
    bif.psr            = p;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {bif.enable_fetch, bif.enable_updatePC, bif.enable_decode, bif.enable_execute,
           bif.enable_writeback, bif.br_taken, bif.mem_state};
    nVectors++;
    assert (obs === exp)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    nVectors           = 0;
    nMiscompares       = 0;
    reset              = 1'b1;
    bif.complete_instr = 1'b1;
    bif.complete_data  = 1'b1;
    bif.IR_Exec        = I_ADD;
    bif.psr            = 3'b000;

    // Reset holds every enable low even with both completes high
    applyStimulus(1, 1, 1, I_ADD, 3'b000); checkOutput("reset_hold",  8'b00000_0_11);
    applyStimulus(1, 1, 1, I_LDR, 3'b111); checkOutput("reset_hold2", 8'b00000_0_11);

    // Pipeline fill with an ADD stream
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("fill_c1",  8'b11000_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("fill_c2",  8'b11100_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("fill_c3",  8'b11110_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("fill_c4",  8'b11111_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("steady",   8'b11111_0_11);

    // Instruction-memory stall freezes everything, then resumes unchanged
    applyStimulus(0, 0, 0, I_ADD, 3'b000); checkOutput("stall_1",  8'b00000_0_11);
    applyStimulus(0, 0, 0, I_ADD, 3'b000); checkOutput("stall_2",  8'b00000_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("resume",   8'b11111_0_11);

    // LDR: hazard cycle, three MEM_RD cycles, writeback on completion
    applyStimulus(0, 1, 0, I_LDR, 3'b000); checkOutput("ldr_haz",  8'b00000_0_11);
    applyStimulus(0, 1, 0, I_LDR, 3'b000); checkOutput("ldr_rd1",  8'b00000_0_00);
    applyStimulus(0, 1, 0, I_LDR, 3'b000); checkOutput("ldr_rd2",  8'b00000_0_00);
    applyStimulus(0, 1, 1, I_LDR, 3'b000); checkOutput("ldr_done", 8'b00001_0_00);
    applyStimulus(0, 1, 0, I_LDR, 3'b000); checkOutput("ldr_ret",  8'b11110_0_11);

    // Unlisted opcode is a NOP; stray complete_data in RUN is ignored
    applyStimulus(0, 1, 1, I_NOP, 3'b000); checkOutput("nop_cd",   8'b11110_0_11);

    // STI: indirect phase of two cycles, then one write cycle, no writeback
    applyStimulus(0, 1, 0, I_STI, 3'b000); checkOutput("sti_haz",  8'b00000_0_11);
    applyStimulus(0, 1, 0, I_STI, 3'b000); checkOutput("sti_ind1", 8'b00000_0_01);
    applyStimulus(0, 1, 1, I_STI, 3'b000); checkOutput("sti_ind2", 8'b00000_0_01);
    applyStimulus(0, 1, 1, I_STI, 3'b000); checkOutput("sti_wr",   8'b00000_0_10);
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("sti_ret",  8'b11110_0_11);

    // Taken BR (nzp=010, psr=010): one BR_WAIT with only updatePC, then refill
    applyStimulus(0, 1, 0, I_BRZ, 3'b010); checkOutput("brt_haz",  8'b00000_0_11);
    applyStimulus(0, 1, 0, I_BRZ, 3'b010); checkOutput("brt_wait", 8'b01000_1_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b010); checkOutput("brt_f1",   8'b11000_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b010); checkOutput("brt_f2",   8'b11100_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b010); checkOutput("brt_f3",   8'b11110_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b010); checkOutput("brt_f4",   8'b11111_0_11);

    // Not-taken BR (psr=100) still flushes
    applyStimulus(0, 1, 0, I_BRZ, 3'b100); checkOutput("brn_haz",  8'b00000_0_11);
    applyStimulus(0, 1, 0, I_BRZ, 3'b100); checkOutput("brn_wait", 8'b01000_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b100); checkOutput("brn_f1",   8'b11000_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b100); checkOutput("brn_f2",   8'b11100_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b100); checkOutput("brn_f3",   8'b11110_0_11);

    // Reset asserted in the middle of an LD read sequence
    applyStimulus(0, 1, 0, I_LD,  3'b000); checkOutput("ld_haz",   8'b00000_0_11);
    applyStimulus(0, 1, 0, I_LD,  3'b000); checkOutput("ld_rd1",   8'b00000_0_00);
    applyStimulus(1, 1, 1, I_LD,  3'b000); checkOutput("ld_rst",   8'b00000_0_11);
    applyStimulus(0, 1, 1, I_LD,  3'b000); checkOutput("post_c1",  8'b11000_0_11);
    applyStimulus(0, 1, 0, I_ADD, 3'b000); checkOutput("post_c2",  8'b11100_0_11);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 SHALL have ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock, all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- complete_instr  input  1  instruction memory has returned Instr_dout for current pc.
- complete_data  input  1  data memory access finished this cycle.
- IR_Exec  input  16  instruction currently held in execute stage; opcode = IR_Exec[15:12].
- psr  input  3  current N,Z,P condition codes.
- enable_fetch  output  1  fetch stage advances; drives instrmem_rd.
- enable_updatePC  output  1  PC register loads next value.
- enable_decode  output  1  decode stage captures fetched instruction.
- enable_execute  output  1  execute stage captures decoded instruction.
- enable_writeback  output  1  register file write this cycle.
- br_taken  output  1  PC loads branch target instead of pc+1.
- mem_state  output  2  data memory sequence: 0 read, 1 indirect read, 2 write, 3 idle.

Function
REQ-002 SHALL implement states RUN, MEM_IND, MEM_RD, MEM_WR, BR_WAIT; state, valid bits v_dec/v_exe, br_taken, mem_state SHALL be flops.
REQ-003 SHALL drive enables combinationally from state, valid bits, complete_instr, complete_data.
REQ-004 RUN, no hazard: enable_fetch = enable_updatePC = complete_instr.
REQ-005 v_dec SHALL load enable_fetch each cycle; enable_decode = v_dec & enable_fetch-stall-free (RUN only).
REQ-006 v_exe SHALL load enable_decode; enable_execute = v_exe in RUN.
REQ-007 enable_writeback SHALL be 1 in RUN the cycle after enable_execute when the executed opcode is ADD(0001), AND(0101), NOT(1001) or LEA(1110).
REQ-008 complete_instr = 0 in RUN SHALL freeze all enables and valid bits (full stall).
REQ-009 LD(0010)/LDR(0110) in execute: next state MEM_RD, mem_state = 0.
REQ-010 LDI(1010)/STI(1011) in execute: next state MEM_IND, mem_state = 1.
REQ-011 ST(0011)/STR(0111) in execute: next state MEM_WR, mem_state = 2.
REQ-012 MEM_IND + complete_data: LDI -> MEM_RD (mem_state 0); STI -> MEM_WR (mem_state 2).
REQ-013 MEM_RD + complete_data: enable_writeback = 1 that cycle, next RUN, mem_state 3.
REQ-014 MEM_WR + complete_data: next RUN, mem_state 3, no writeback.
REQ-015 In any MEM_* state all enables except REQ-013 writeback SHALL be 0; without complete_data the state SHALL hold indefinitely.
REQ-016 BR(0000) or JMP(1100) in execute: next BR_WAIT; br_taken registered = 1 for JMP, (IR_Exec[11:9] & psr) != 0 for BR.
REQ-017 BR_WAIT lasts exactly 1 cycle: enable_updatePC = 1, other enables 0; v_dec, v_exe cleared (flush); next RUN.
REQ-018 br_taken SHALL return to 0 on the cycle after BR_WAIT.
REQ-019 BR with IR_Exec[11:9] = 000 SHALL be not-taken but still flush.
REQ-020 Unlisted opcodes in execute SHALL act as NOP: no writeback, no state change.
REQ-021 complete_data outside MEM_* states SHALL be ignored.

Reset
REQ-022 reset high SHALL immediately force state RUN, v_dec = v_exe = 0, br_taken = 0, mem_state = 3.
REQ-023 During reset all enable outputs SHALL be 0 regardless of inputs.
REQ-024 reset mid memory or branch sequence SHALL abandon it; first cycle after deassert with complete_instr = 1 SHALL give enable_fetch = 1, enable_decode = 0.
REQ-025 After reset, pipeline fill SHALL take 2 cycles: decode enabled cycle 2, execute cycle 3.

Verification
REQ-026 Reset release, complete_instr held 1, ADD stream -> fetch cycle 1, decode cycle 2, execute cycle 3, writeback cycle 4, then all 1 each cycle.
REQ-027 LDR in execute, complete_data after 3 cycles -> mem_state 0 for 3 cycles, enables 0, writeback 1 on completion cycle, mem_state 3 next.
REQ-028 STI, complete_data after 2 cycles then after 1 -> mem_state 1,1 then 2, no writeback, return RUN.
REQ-029 BR IR_Exec[11:9] = 010, psr = 010 -> br_taken 1, one BR_WAIT with only enable_updatePC, decode/execute 0 for next 2 cycles; psr = 100 -> br_taken 0, same flush.
REQ-030 complete_instr toggling 1,0,0,1 in RUN -> enables frozen for the two 0 cycles, resume unchanged.
REQ-031 reset asserted mid MEM_RD -> outputs zero and mem_state 3 immediately, no writeback after deassert.
